// File: rtl/btn_conditioner.sv
// Pushbutton conditioning: sync, debounce, edge pulses and
// game-tick aligned press events, one identical channel per button.
module btn_conditioner #(
  parameter int NUM_BTN   = 4,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_tick,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_event
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] sync;
  logic [NUM_BTN-1:0] pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= btn_raw;
      sync <= s1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;

    // Any sample equal to the accepted level restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt            <= '0;
        btn_level[i]   <= 1'b0;
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
      end else begin
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
        if (sync[i] == btn_level[i]) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          cnt            <= '0;
          btn_level[i]   <= sync[i];
          btn_press[i]   <= sync[i];
          btn_release[i] <= ~sync[i];
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end

    // A press landing in the tick cycle is delivered now, not held.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pending[i]   <= 1'b0;
        btn_event[i] <= 1'b0;
      end else if (game_tick) begin
        btn_event[i] <= pending[i] | btn_press[i];
        pending[i]   <= 1'b0;
      end else begin
        btn_event[i] <= 1'b0;
        if (btn_press[i]) begin
          pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a 4-cycle debounce window.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_tick;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_event;

  int total  = 0;
  int passed = 0;
  int press2_cnt = 0;
  int base;

  btn_conditioner #(
    .NUM_BTN(4),
    .DB_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .game_tick(game_tick),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_event(btn_event)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (btn_press[2]) press2_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    game_tick = 1'b1;
    step(1);
    game_tick = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    game_tick = 1'b0;
    btn_raw   = 4'b0000;
    #12;
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk("rst_rel",   32'(btn_release), 32'h0);
    chk("rst_event", 32'(btn_event), 32'h0);
    step(1);
    rst_n = 1'b1;

    // clean press on U
    btn_raw = 4'b0010;
    step(5);
    chk("t1_lvl_early", 32'(btn_level), 32'h0);
    step(1);
    chk("t1_lvl",   32'(btn_level), 32'h2);
    chk("t1_press", 32'(btn_press), 32'h2);
    chk("t1_rel",   32'(btn_release), 32'h0);
    step(1);
    chk("t1_press_off", 32'(btn_press), 32'h0);

    // event alignment
    step(10);
    chk("t3_no_event", 32'(btn_event), 32'h0);
    tick();
    chk("t3_event", 32'(btn_event), 32'h2);
    step(1);
    chk("t3_event_off", 32'(btn_event), 32'h0);
    step(5);
    tick();
    chk("t3_second_tick", 32'(btn_event), 32'h0);

    // 3-clk glitch on R
    btn_raw[3] = 1'b1;
    step(3);
    btn_raw[3] = 1'b0;
    step(10);
    chk("t2_glitch", 32'(btn_level), 32'h2);

    // bounce on L
    base = press2_cnt;
    for (int k = 0; k < 2; k++) begin
      btn_raw[2] = 1'b1;
      step(2);
      btn_raw[2] = 1'b0;
      step(2);
    end
    btn_raw[2] = 1'b1;
    step(5);
    chk("t2_lvl_early", 32'(btn_level), 32'h2);
    step(1);
    chk("t2_lvl", 32'(btn_level), 32'h6);
    step(4);
    chk("t2_press_cnt", 32'(press2_cnt - base), 32'd1);

    tick();
    chk("t4_clear", 32'(btn_event), 32'h4);

    // two press/release cycles of S between ticks
    for (int k = 0; k < 2; k++) begin
      btn_raw[0] = 1'b1;
      step(8);
      btn_raw[0] = 1'b0;
      step(8);
    end
    chk("t4_lvl", 32'(btn_level), 32'h6);
    tick();
    chk("t4_coalesce", 32'(btn_event), 32'h1);
    step(3);
    tick();
    chk("t4_once", 32'(btn_event), 32'h0);

    // press of R coincident with the tick
    btn_raw[3] = 1'b1;
    step(6);
    chk("t4_press3", 32'(btn_press), 32'h8);
    tick();
    chk("t4_coincide", 32'(btn_event), 32'h8);
    step(2);
    tick();
    chk("t4_pend_clr", 32'(btn_event), 32'h0);

    // release and independence
    btn_raw = 4'b0100;
    step(8);
    chk("t5_lvl_a", 32'(btn_level), 32'h4);
    btn_raw = 4'b0101;
    step(8);
    chk("t5_lvl_b", 32'(btn_level), 32'h5);
    btn_raw = 4'b0100;
    step(6);
    chk("t5_rel",     32'(btn_release), 32'h1);
    chk("t5_nopress", 32'(btn_press), 32'h0);
    chk("t5_lvl_c",   32'(btn_level), 32'h4);
    step(1);
    chk("t5_rel_off", 32'(btn_release), 32'h0);
    btn_raw = 4'b0000;
    step(8);
    chk("t5_all_off", 32'(btn_level), 32'h0);
    btn_raw = 4'b1111;
    step(6);
    chk("t5_press_all", 32'(btn_press), 32'hf);
    chk("t5_lvl_all",   32'(btn_level), 32'hf);

    // reset mid-operation
    btn_raw = 4'b0000;
    step(8);
    tick();
    btn_raw = 4'b0010;
    step(8);
    chk("t6_lvl", 32'(btn_level), 32'h2);
    btn_raw = 4'b0000;
    step(4);
    btn_raw = 4'b0010;
    rst_n = 1'b0;
    #1;
    chk("t6_async_lvl", 32'(btn_level), 32'h0);
    chk("t6_async_evt", 32'(btn_event), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("t6_no_event", 32'(btn_event), 32'h0);
    step(4);
    chk("t6_lvl_early", 32'(btn_level), 32'h0);
    step(1);
    chk("t6_press", 32'(btn_press), 32'h2);
    step(2);
    tick();
    chk("t6_event", 32'(btn_event), 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
